// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_txrx block.
//   DATA_BITS         - payload bits per frame
//   CLKS_PER_BIT_DEF  - default system clocks per serial bit
//   tx_state_e        - transmitter FSM states
//   rx_state_e        - receiver FSM states
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 87;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_STOP    = 3'd3,
    TX_CLEANUP = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with clear, enable and a
// terminal-count flag. The counter wraps to zero on its own when the
// terminal value is reached, so back-to-back bit periods need no clear.
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   clr   - force count to zero (wins over en)
//   en    - advance the count
//   last  - terminal value (count == last raises tc)
//   tc    - terminal count reached this cycle (only while enabled)
module uart_bit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = en && (count == last);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex 8N1 UART transmitter and receiver sharing one clock.
//   CLKS_PER_BIT - system clocks per serial bit (4..65535)
//   i_Clock      - system clock, rising edge
//   i_Rst_n      - synchronous active-low reset
//   i_Tx_DV      - transmit request, sampled only while TX is idle
//   i_Tx_Byte    - byte to send, captured when the request is accepted
//   o_Tx_Active  - high from start bit until end of stop bit
//   o_Tx_Serial  - serial output, idles high
//   o_Tx_Done    - one-cycle pulse after the stop bit
//   i_Rx_Serial  - asynchronous serial input
//   o_Rx_DV      - one-cycle pulse when a byte with a valid stop bit arrives
//   o_Rx_Byte    - last valid received byte, held between frames
module uart_txrx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [2:0] tx_idx_q, tx_idx_d, tx_idx_inc;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_serial_q, tx_serial_d;
  logic       tx_active_q, tx_active_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_tmr_clr, tx_tmr_en, tx_tmr_tc;

  uart_bit_timer #(.WIDTH(16)) u_tx_timer (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .clr   (tx_tmr_clr),
    .en    (tx_tmr_en),
    .last  (BIT_LAST),
    .tc    (tx_tmr_tc)
  );

  assign tx_idx_inc = tx_idx_q + 3'd1;

  // Line level is registered so it changes on the edge the state changes.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_idx_d    = tx_idx_q;
    tx_byte_d   = tx_byte_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    tx_tmr_clr  = 1'b0;
    tx_tmr_en   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_serial_d = 1'b1;
        tx_tmr_clr  = 1'b1;
        tx_idx_d    = '0;
        if (i_Tx_DV) begin
          tx_byte_d   = i_Tx_Byte;
          tx_active_d = 1'b1;
          tx_serial_d = 1'b0;
          tx_state_d  = TX_START;
        end
      end
      TX_START: begin
        tx_tmr_en = 1'b1;
        if (tx_tmr_tc) begin
          tx_serial_d = tx_byte_q[0];
          tx_state_d  = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_tmr_en = 1'b1;
        if (tx_tmr_tc) begin
          if (tx_idx_q == IDX_LAST) begin
            tx_idx_d    = '0;
            tx_serial_d = 1'b1;
            tx_state_d  = TX_STOP;
          end else begin
            tx_idx_d    = tx_idx_inc;
            tx_serial_d = tx_byte_q[tx_idx_inc];
          end
        end
      end
      TX_STOP: begin
        tx_tmr_en = 1'b1;
        if (tx_tmr_tc) begin
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          tx_state_d  = TX_CLEANUP;
        end
      end
      TX_CLEANUP: tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_idx_q    <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_idx_q    <= tx_idx_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Payload holding register carries no reset; it is always loaded on accept.
  always_ff @(posedge i_Clock) begin
    tx_byte_q <= tx_byte_d;
  end

  assign o_Tx_Serial = tx_serial_q;
  assign o_Tx_Active = tx_active_q;
  assign o_Tx_Done   = tx_done_q;

  // ---------------- receiver ----------------
  logic       rx_sync1, rx_sync2;
  rx_state_e  rx_state_q, rx_state_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic       rx_tmr_clr, rx_tmr_en, rx_tmr_tc;
  logic [15:0] rx_tmr_last;

  // Two-flop synchroniser; idles at the line's mark level.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
    end else begin
      rx_sync1 <= i_Rx_Serial;
      rx_sync2 <= rx_sync1;
    end
  end

  // Half a bit in START lands later samples on bit centres; the timer's
  // self-wrap at that point restarts the full-bit count.
  assign rx_tmr_last = (rx_state_q == RX_START) ? HALF_LAST : BIT_LAST;

  uart_bit_timer #(.WIDTH(16)) u_rx_timer (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .clr   (rx_tmr_clr),
    .en    (rx_tmr_en),
    .last  (rx_tmr_last),
    .tc    (rx_tmr_tc)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    rx_tmr_clr = 1'b0;
    rx_tmr_en  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_tmr_clr = 1'b1;
        rx_idx_d   = '0;
        if (!rx_sync2) rx_state_d = RX_START;
      end
      RX_START: begin
        rx_tmr_en = 1'b1;
        if (rx_tmr_tc) rx_state_d = rx_sync2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        rx_tmr_en = 1'b1;
        if (rx_tmr_tc) begin
          rx_shift_d[rx_idx_q] = rx_sync2;
          if (rx_idx_q == IDX_LAST) begin
            rx_idx_d   = '0;
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        rx_tmr_en = 1'b1;
        if (rx_tmr_tc) begin
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_sync2) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
          rx_state_d = RX_CLEANUP;
        end
      end
      RX_CLEANUP: rx_state_d = RX_IDLE;
      default:    rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    rx_shift_q <= rx_shift_d;
  end

  assign o_Rx_DV   = rx_dv_q;
  assign o_Rx_Byte = rx_byte_q;

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: loopback bench for uart_txrx at CLKS_PER_BIT 87 and 4.
// A scoreboard queues every byte the transmitter accepts and expects the
// receiver to hand them back in order; frame lines are decoded at bit
// centres and compared with the 8N1 format built from the byte.
`timescale 1ns/1ps
module tb_uart_txrx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tx_dv87, tx_dv4;
  logic [7:0] tx_byte87, tx_byte4;
  logic       tx_act87, tx_ser87, tx_done87, rx_dv87;
  logic       tx_act4, tx_ser4, tx_done4, rx_dv4;
  logic [7:0] rx_byte87, rx_byte4;
  logic       rx_ovr87, rx_drv87, rx_line87;

  assign rx_line87 = rx_ovr87 ? rx_drv87 : tx_ser87;

  uart_txrx #(.CLKS_PER_BIT(87)) dut87 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(tx_dv87), .i_Tx_Byte(tx_byte87),
    .o_Tx_Active(tx_act87), .o_Tx_Serial(tx_ser87), .o_Tx_Done(tx_done87),
    .i_Rx_Serial(rx_line87), .o_Rx_DV(rx_dv87), .o_Rx_Byte(rx_byte87)
  );

  uart_txrx #(.CLKS_PER_BIT(4)) dut4 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(tx_dv4), .i_Tx_Byte(tx_byte4),
    .o_Tx_Active(tx_act4), .o_Tx_Serial(tx_ser4), .o_Tx_Done(tx_done4),
    .i_Rx_Serial(tx_ser4), .o_Rx_DV(rx_dv4), .o_Rx_Byte(rx_byte4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receive latency from TX accept to DV, with a small allowance for how
  // the edge-to-edge count is taken.
  function automatic logic lat_ok(input int lat, input int c);
    int e;
    e = 2 + (c - 1) / 2 + 9 * c + 1;
    return (lat >= e - 1) && (lat <= e + 2);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards
  logic [7:0] exp_q0[$], exp_q1[$];
  int         starts0[$];
  int         start0 = 0, start1 = 0;
  int         done_cnt0 = 0, done_cnt1 = 0, dv_cnt0 = 0, dv_cnt1 = 0;
  logic       act0_q = 1'b0, act1_q = 1'b0;
  logic [7:0] e0, e1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_act87 && !act0_q) begin
        exp_q0.push_back(tx_byte87);
        start0 = cyc;
        starts0.push_back(cyc);
      end
      if (tx_done87) done_cnt0++;
      if (rx_dv87) begin
        dv_cnt0++;
        if (exp_q0.size() == 0) check_eq("rx87_expected_pending", exp_q0.size(), 1);
        else begin
          e0 = exp_q0.pop_front();
          check_eq("rx87_byte", rx_byte87, e0);
          if (!rx_ovr87) check_eq("rx87_latency_in_window", lat_ok(cyc - start0, 87), 1);
        end
      end
      if (tx_act4 && !act1_q) begin
        exp_q1.push_back(tx_byte4);
        start1 = cyc;
      end
      if (tx_done4) done_cnt1++;
      if (rx_dv4) begin
        dv_cnt1++;
        if (exp_q1.size() == 0) check_eq("rx4_expected_pending", exp_q1.size(), 1);
        else begin
          e1 = exp_q1.pop_front();
          check_eq("rx4_byte", rx_byte4, e1);
          check_eq("rx4_latency_in_window", lat_ok(cyc - start1, 4), 1);
        end
      end
    end
    act0_q = (tx_act87 === 1'b1);
    act1_q = (tx_act4 === 1'b1);
  end

  function automatic logic ser_of(input int w);
    return (w == 0) ? tx_ser87 : tx_ser4;
  endfunction
  function automatic logic act_of(input int w);
    return (w == 0) ? tx_act87 : tx_act4;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? tx_done87 : tx_done4;
  endfunction

  // Pulse a request and decode the line at each bit centre.
  task automatic run_frame(input int w, input logic [7:0] b);
    int c, d0;
    logic [9:0] seen, want;
    c    = (w == 0) ? 87 : 4;
    want = {1'b1, b, 1'b0};
    seen = '0;
    d0   = (w == 0) ? done_cnt0 : done_cnt1;
    @(negedge clk);
    if (w == 0) begin tx_byte87 = b; tx_dv87 = 1'b1; end
    else        begin tx_byte4  = b; tx_dv4  = 1'b1; end
    @(negedge clk);
    if (w == 0) tx_dv87 = 1'b0; else tx_dv4 = 1'b0;
    check_eq("tx_active_rise", act_of(w), 1'b1);
    for (int k = 0; k < 10; k++) begin
      repeat (c / 2) @(negedge clk);
      seen[k] = ser_of(w);
      repeat (c - c / 2) @(negedge clk);
    end
    check_eq("tx_line_bits", seen, want);
    check_eq("tx_done_pulse", done_of(w), 1'b1);
    check_eq("tx_active_fall", act_of(w), 1'b0);
    @(negedge clk);
    check_eq("tx_done_width", done_of(w), 1'b0);
    repeat (4) @(negedge clk);
    check_eq("tx_done_count", ((w == 0) ? done_cnt0 : done_cnt1) - d0, 1);
    check_eq("rx_pending", (w == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  // Bit-bang a frame onto the 87-clock receiver with a chosen stop level.
  task automatic send_raw(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rx_drv87 = bits[k];
      repeat (87) @(negedge clk);
    end
    rx_drv87 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         d_dv, d_done, w;
  logic [7:0] held;

  initial begin
    rst_n     = 1'b0;
    tx_dv87   = 1'b0; tx_byte87 = 8'h0A;
    tx_dv4    = 1'b0; tx_byte4  = 8'h00;
    rx_ovr87  = 1'b0; rx_drv87  = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_tx_serial", tx_ser87, 1'b1);
    check_eq("rst_tx_active", tx_act87, 1'b0);
    check_eq("rst_tx_done", tx_done87, 1'b0);
    check_eq("rst_rx_dv", rx_dv87, 1'b0);
    check_eq("rst_rx_byte", rx_byte87, 8'h00);
    check_eq("rst4_tx_serial", tx_ser4, 1'b1);
    check_eq("rst4_rx_byte", rx_byte4, 8'h00);
    rst_n = 1'b1;
    while ($time < 100) @(negedge clk);

    // Held request: back-to-back frames at the minimum period.
    starts0.delete();
    d_dv = dv_cnt0; d_done = done_cnt0;
    tx_byte87 = 8'h2D; tx_dv87 = 1'b1;
    w = 0;
    while (starts0.size() < 3 && w < 4 * 872) begin
      @(negedge clk);
      w++;
    end
    tx_dv87 = 1'b0;
    check_eq("held_starts_seen", starts0.size(), 3);
    repeat (11 * 87 + 10) @(negedge clk);
    if (starts0.size() >= 3) begin
      check_eq("held_period_1", starts0[1] - starts0[0], 10 * 87 + 2);
      check_eq("held_period_2", starts0[2] - starts0[1], 10 * 87 + 2);
    end
    check_eq("held_done_count", done_cnt0 - d_done, 3);
    check_eq("held_dv_count", dv_cnt0 - d_dv, 3);
    check_eq("held_last_byte", rx_byte87, 8'h2D);
    check_eq("held_pending", exp_q0.size(), 0);

    // Single frame plus randomized loopback.
    run_frame(0, 8'h2D);
    check_eq("loop_2d_byte", rx_byte87, 8'h2D);
    for (int i = 0; i < 6; i++) run_frame(0, 8'($urandom));

    // Short low glitch must not start a frame.
    held = rx_byte87; d_dv = dv_cnt0;
    rx_ovr87 = 1'b1; rx_drv87 = 1'b1;
    repeat (5) @(negedge clk);
    rx_drv87 = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv87 = 1'b1;
    repeat (3 * 87) @(negedge clk);
    check_eq("glitch_no_dv", dv_cnt0 - d_dv, 0);
    check_eq("glitch_byte_held", rx_byte87, held);

    // Framing error, then a good frame.
    send_raw(8'hA5, 1'b0);
    repeat (3 * 87) @(negedge clk);
    check_eq("frame_err_no_dv", dv_cnt0 - d_dv, 0);
    check_eq("frame_err_byte_held", rx_byte87, held);
    exp_q0.push_back(8'h3C);
    send_raw(8'h3C, 1'b1);
    repeat (2 * 87) @(negedge clk);
    check_eq("after_err_dv", dv_cnt0 - d_dv, 1);
    check_eq("after_err_byte", rx_byte87, 8'h3C);
    check_eq("after_err_pending", exp_q0.size(), 0);
    rx_ovr87 = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame on both directions.
    d_dv = dv_cnt0; d_done = done_cnt0;
    @(negedge clk);
    tx_byte87 = 8'hC3; tx_dv87 = 1'b1;
    @(negedge clk);
    tx_dv87 = 1'b0;
    repeat (3 * 87) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_tx_serial", tx_ser87, 1'b1);
    check_eq("midrst_tx_active", tx_act87, 1'b0);
    check_eq("midrst_rx_byte", rx_byte87, 8'h00);
    rst_n = 1'b1;
    exp_q0.delete();
    repeat (12 * 87) @(negedge clk);
    check_eq("midrst_no_dv", dv_cnt0 - d_dv, 0);
    check_eq("midrst_no_done", done_cnt0 - d_done, 0);
    run_frame(0, 8'($urandom));

    // Minimum divisor.
    run_frame(1, 8'h00);
    check_eq("div4_byte_00", rx_byte4, 8'h00);
    run_frame(1, 8'hFF);
    check_eq("div4_byte_ff", rx_byte4, 8'hFF);
    for (int i = 0; i < 8; i++) run_frame(1, 8'($urandom));

    repeat (20) @(negedge clk);
    check_eq("final_pending87", exp_q0.size(), 0);
    check_eq("final_pending4", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
